// File: rtl/cia_icr_unit_if.sv
// rtl/cia_icr_unit_if.sv - CPU-side register bus for the CIA ICR (address 0xD)
interface cia_icr_unit_if;
  logic       rd;
  logic       we;
  logic [3:0] addr;
  logic [7:0] data;
  logic [7:0] icr_data;
  logic [4:0] icr_mask;

  modport master (
    output rd,
    output we,
    output addr,
    output data,
    input  icr_data,
    input  icr_mask
  );

  modport slave (
    input  rd,
    input  we,
    input  addr,
    input  data,
    output icr_data,
    output icr_mask
  );
endinterface

// File: rtl/cia_icr_unit.sv
// rtl/cia_icr_unit.sv - CIA interrupt control register: flags, mask, IR and /IRQ
module cia_icr_unit (
  input  logic               clk,
  input  logic               res,
  input  logic               chip,
  input  logic               phi2_dn,
  input  logic [4:0]         sources,
  cia_icr_unit_if.slave      bus,
  output logic               irq_n
);

  localparam logic [3:0] ICR_ADDR = 4'hD;

  logic [4:0] flags_q, flags_d;
  logic [4:0] mask_q, mask_d;
  logic       ir_q, ir_d;
  logic       pending_q, pending_d;
  logic       irq_n_q;

  logic       readclr;
  logic       wr;
  logic [4:0] flags_kept;
  logic       ir_kept;
  logic       pending_kept;
  logic       match;

  assign readclr = phi2_dn & bus.rd & (bus.addr == ICR_ADDR);
  assign wr      = phi2_dn & bus.we & (bus.addr == ICR_ADDR);

  always_comb begin
    mask_d = mask_q;
    if (wr) begin
      if (bus.data[7]) mask_d = mask_q | bus.data[4:0];
      else             mask_d = mask_q & ~bus.data[4:0];
    end

    // A read-clear wipes state first; sources on the same edge then re-set it.
    flags_kept   = readclr ? 5'd0 : flags_q;
    ir_kept      = readclr ? 1'b0 : ir_q;
    pending_kept = readclr ? 1'b0 : pending_q;

    flags_d = flags_kept | sources;
    match   = |(flags_d & mask_d);

    pending_d = 1'b0;
    ir_d      = ir_kept;
    if (chip) begin
      ir_d = ir_kept | match;
    end else begin
      // 6526 delays IR by one PHI2 cycle through the pending stage.
      pending_d = match & ~ir_kept;
      ir_d      = ir_kept | pending_kept;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      flags_q   <= 5'd0;
      mask_q    <= 5'd0;
      ir_q      <= 1'b0;
      pending_q <= 1'b0;
      irq_n_q   <= 1'b1;
    end else if (phi2_dn) begin
      flags_q   <= flags_d;
      mask_q    <= mask_d;
      ir_q      <= ir_d;
      pending_q <= pending_d;
      irq_n_q   <= ~ir_d;
    end
  end

  assign bus.icr_data = {ir_q, 2'b00, flags_q};
  assign bus.icr_mask = mask_q;
  assign irq_n        = irq_n_q;

endmodule

// File: tb/tb_cia_icr_unit.sv
// tb/tb_cia_icr_unit.sv - directed self-checking bench for cia_icr_unit
module tb_cia_icr_unit;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       chip = 1'b0;
  logic       phi2_dn = 1'b0;
  logic [4:0] sources = 5'd0;
  logic       irq_n;

  int compared = 0;
  int mismatched = 0;

  cia_icr_unit_if bus ();

  cia_icr_unit dut (
    .clk     (clk),
    .res     (res),
    .chip    (chip),
    .phi2_dn (phi2_dn),
    .sources (sources),
    .bus     (bus.slave),
    .irq_n   (irq_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_bus();
    phi2_dn  = 1'b0;
    bus.rd   = 1'b0;
    bus.we   = 1'b0;
    bus.addr = 4'h0;
    bus.data = 8'h00;
    sources  = 5'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_bus();
    res = 1'b1;
    @(posedge clk);
    #1 res = 1'b0;
  endtask

  task automatic edge_cyc(input logic r, input logic w, input logic [3:0] a,
                          input logic [7:0] d, input logic [4:0] s);
    @(negedge clk);
    bus.rd = r; bus.we = w; bus.addr = a; bus.data = d; sources = s;
    phi2_dn = 1'b1;
    @(posedge clk);
    #1 clear_bus();
  endtask

  task automatic wr_icr(input logic [7:0] d);
    edge_cyc(1'b0, 1'b1, 4'hD, d, 5'd0);
  endtask

  task automatic rd_icr(input string tag, input logic [7:0] exp, input logic [4:0] s);
    @(negedge clk);
    bus.rd = 1'b1; bus.we = 1'b0; bus.addr = 4'hD; bus.data = 8'h00; sources = s;
    phi2_dn = 1'b1;
    #1 check(tag, bus.icr_data, exp);
    @(posedge clk);
    #1 clear_bus();
  endtask

  task automatic check_state(input string tag, input logic [7:0] icr,
                             input logic [4:0] mask, input logic irqn);
    check({tag, ".icr"}, bus.icr_data, icr);
    check({tag, ".mask"}, {3'b000, bus.icr_mask}, {3'b000, mask});
    check({tag, ".irq_n"}, {7'd0, irq_n}, {7'd0, irqn});
  endtask

  initial begin
    clear_bus();
    res = 1'b1;
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
    check_state("reset", 8'h00, 5'h00, 1'b1);

    // sources without a strobe must not be captured
    chip = 1'b1;
    @(negedge clk);
    sources = 5'h01;
    repeat (3) @(posedge clk);
    #1 sources = 5'd0;
    check_state("no_strobe", 8'h00, 5'h00, 1'b1);

    // 8521: flag, then mask enable -> immediate IR
    edge_cyc(1'b0, 1'b0, 4'h0, 8'h00, 5'h01);
    check_state("c1_flag", 8'h01, 5'h00, 1'b1);
    wr_icr(8'h81);
    check_state("c1_enable", 8'h81, 5'h01, 1'b0);

    // reset mid-interrupt, no phi2_dn needed
    do_reset();
    check_state("reset_mid", 8'h00, 5'h00, 1'b1);

    // 6526: mask enable -> IR one edge later, then read-clear
    chip = 1'b0;
    edge_cyc(1'b0, 1'b0, 4'h0, 8'h00, 5'h01);
    check_state("c0_flag", 8'h01, 5'h00, 1'b1);
    wr_icr(8'h81);
    check_state("c0_enable", 8'h01, 5'h01, 1'b1);
    edge_cyc(1'b0, 1'b0, 4'h0, 8'h00, 5'h00);
    check_state("c0_delayed", 8'h81, 5'h01, 1'b0);
    rd_icr("c0_read", 8'h81, 5'h00);
    check_state("c0_after_read", 8'h00, 5'h01, 1'b1);

    // mask set/clear rules, bits 6:5 ignored
    do_reset();
    wr_icr(8'h9F);
    check_state("mask_set", 8'h00, 5'h1F, 1'b1);
    wr_icr(8'h05);
    check_state("mask_clr", 8'h00, 5'h1A, 1'b1);
    wr_icr(8'h60);
    check_state("mask_60", 8'h00, 5'h1A, 1'b1);

    // other addresses have no effect
    edge_cyc(1'b0, 1'b1, 4'hC, 8'h9F, 5'h00);
    check_state("wr_other", 8'h00, 5'h1A, 1'b1);

    // 6526 source with mask 0x02
    do_reset();
    chip = 1'b0;
    wr_icr(8'h82);
    edge_cyc(1'b0, 1'b0, 4'h0, 8'h00, 5'h02);
    check_state("c0_k", 8'h02, 5'h02, 1'b1);
    edge_cyc(1'b0, 1'b0, 4'h0, 8'h00, 5'h00);
    check_state("c0_k1", 8'h82, 5'h02, 1'b0);
    edge_cyc(1'b1, 1'b0, 4'hC, 8'h00, 5'h00);
    check_state("rd_other", 8'h82, 5'h02, 1'b0);
    rd_icr("c0_rd82", 8'h82, 5'h00);
    check_state("c0_rd82_after", 8'h00, 5'h02, 1'b1);

    // 8521: read-clear coincident with sources[4]
    do_reset();
    chip = 1'b1;
    wr_icr(8'h90);
    edge_cyc(1'b0, 1'b0, 4'h0, 8'h00, 5'h01);
    check_state("c1_pre", 8'h01, 5'h10, 1'b1);
    rd_icr("c1_rd_same", 8'h01, 5'h10);
    check_state("c1_rd_same_after", 8'h90, 5'h10, 1'b0);

    // 6526: same collision, IR one edge later
    do_reset();
    chip = 1'b0;
    wr_icr(8'h90);
    rd_icr("c0_rd_same", 8'h00, 5'h10);
    check_state("c0_rd_same_after", 8'h10, 5'h10, 1'b1);
    edge_cyc(1'b0, 1'b0, 4'h0, 8'h00, 5'h00);
    check_state("c0_rd_same_k1", 8'h90, 5'h10, 1'b0);

    // 6526: read-clear on the intervening edge cancels pending
    do_reset();
    chip = 1'b0;
    wr_icr(8'h84);
    edge_cyc(1'b0, 1'b0, 4'h0, 8'h00, 5'h04);
    check_state("cancel_k", 8'h04, 5'h04, 1'b1);
    rd_icr("cancel_rd", 8'h04, 5'h00);
    check_state("cancel_k1", 8'h00, 5'h04, 1'b1);
    edge_cyc(1'b0, 1'b0, 4'h0, 8'h00, 5'h00);
    check_state("cancel_k2", 8'h00, 5'h04, 1'b1);

    // IR holds across mask disable and repeated source pulses
    do_reset();
    chip = 1'b1;
    wr_icr(8'h81);
    edge_cyc(1'b0, 1'b0, 4'h0, 8'h00, 5'h01);
    check_state("hold_set", 8'h81, 5'h01, 1'b0);
    wr_icr(8'h01);
    check_state("hold_maskoff", 8'h81, 5'h00, 1'b0);
    edge_cyc(1'b0, 1'b0, 4'h0, 8'h00, 5'h01);
    check_state("hold_repeat", 8'h81, 5'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cia_icr_unit.md
Name: cia_icr_unit

Overview:
- Interrupt Control Register (ICR, address 0xD) of the CIA (6526/8521 family).
- Latches the five interrupt sources into flags, holds the interrupt mask, and drives the open-drain IRQ request.
- Sits beside the timers, TOD, serial port and /FLAG edge detector in the CIA core.
- Exposes the ICR read value and mask to the core's register map.

Parameters:
- none (chip variant is a runtime input)

Ports:
- clk  input  1  FPGA system clock; all state on rising edge
- res  input  1  synchronous active-high reset (FPGA reset OR bus /RES)
- chip  input  1  0 = MOS6526 (delayed IRQ), 1 = MOS8521 (immediate IRQ)
- phi2_dn  input  1  one-clk strobe marking PHI2 falling edge; sole update point for ICR state
- rd  input  1  bus read cycle in progress (PHI2 high, CS active, R/W=1)
- we  input  1  bus write cycle in progress (PHI2 high, CS active, R/W=0)
- addr  input  4  register address
- data  input  8  CPU write data
- sources  input  5  {flag, sp, tod, tb, ta}: request bits, sampled only on phi2_dn
- icr_data  output  8  read value: {ir, 2'b00, flags[4:0]}
- icr_mask  output  5  current interrupt mask
- irq_n  output  1  active-low interrupt request

Behaviour:
- Only one clock is used and reset is synchronous and active-high (ports clk, res).
- Reset has priority over all other inputs and needs no phi2_dn:
  - flags=0, mask=0, ir=0, pending=0, irq_n=1.
- No state changes except on a clk edge with phi2_dn=1 or res=1.
- Write event:
  - Condition: we & addr==0xD at phi2_dn.
  - data[7]=1: mask |= data[4:0].
  - data[7]=0: mask &= ~data[4:0].
  - data[6:5] are ignored.
- Read-clear event:
  - Condition: rd & addr==0xD at phi2_dn.
  - The read value is the pre-edge icr_data, driven combinationally.
  - Afterwards flags, ir and pending are cleared.
- Flag update at each phi2_dn: flags_next = (readclr ? 0 : flags) | sources.
  - A source active in the same cycle as a read-clear survives; the flag is set after the clear.
- Match: m = |(flags_next & mask_next).
  - A mask write that enables an already-set flag produces a match.
  - A mask write that disables a flag does not clear an already-set ir.
- 8521 (chip=1):
  - ir_next = (readclr ? 0 : ir) | m.
  - IR and irq_n assert on the same phi2_dn as the flag.
- 6526 (chip=0):
  - pending_next = m & ~ir_after_clear.
  - ir_next = (readclr ? 0 : ir) | pending.
  - IR and irq_n assert one PHI2 cycle (next phi2_dn) after the flag.
  - A read-clear on the intervening edge cancels pending, unless a new match occurs on that edge.
- irq_n = ~ir, registered (changes only on phi2_dn/reset edges).
- ir stays set until a read-clear, regardless of later mask changes or sources deasserting.
- Flags set regardless of mask, and are readable with ir=0.
- Repeated source pulses while a flag is set have no extra effect.
- rd and we are never simultaneous.
- Other addresses have no effect.

Test Plan:
- Reset, then read ICR: icr_data=0x00, icr_mask=0, irq_n=1. Repeat with res asserted mid-interrupt: all return to these values on the next clk.
- Mask off, pulse sources[0] for one phi2_dn: icr_data=0x01, irq_n stays 1. Then write 0x81 to 0xD:
  - chip=1: icr_data=0x81 and irq_n=0 after that phi2_dn.
  - chip=0: same result one phi2_dn later.
- Mask write rules: write 0x9F, then 0x05 → icr_mask=0x1A. Write 0x60 → icr_mask unchanged.
- chip=0, mask 0x02, pulse sources[1]:
  - Edge k: icr_data=0x02, irq_n=1.
  - Edge k+1: icr_data=0x82, irq_n=0.
  - Read ICR: returns 0x82; afterwards 0x00, irq_n=1.
- Read ICR on the same phi2_dn as a sources[4] pulse with mask 0x10: read returns the old value. Flag 0x10 is set afterwards, and ir re-asserts per chip timing (chip=1: immediately, icr_data=0x90).
- chip=0, match at edge k, read-clear at edge k+1 with no new source: irq_n never goes low, icr_data=0x00 after k+1.
